tc_b_tile_loader: RTL and testbench

Upstream packer for the B-operand path of the tensor-core datapath. It accepts B one tile row per beat under a valid/ready handshake and assembles complete NUM_TILE-element tiles in a two-bank ping-pong buffer. It presents each finished tile, row-major, to the B distribution network, which performs the transpose and the broadcast to the PEs. Short tiles are terminated with in_last and zero-padded.

---
 rtl/tc_b_tile_loader.sv | 78 +++++++
 tb/tb_tc_b_tile_loader.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/tc_b_tile_loader.sv
// B-operand tile packer: collects STEP row beats into NUM_TILE-element tiles held in
// a two-bank ping-pong buffer and presents finished tiles row-major downstream.
module tc_b_tile_loader #(
    parameter int NUM_TILE = 16,
    parameter int STEP     = 4,
    parameter int DW_DATA  = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [STEP*DW_DATA-1:0]     in_row,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NUM_TILE*DW_DATA-1:0] out_b,
    output logic [15:0]                 tile_cnt
);
    localparam int ROW_W = (STEP > 1) ? $clog2(STEP) : 1;
    localparam int RW    = STEP * DW_DATA;

    logic [1:0][STEP-1:0][RW-1:0] bank;
    logic                         wr_bank;
    logic                         rd_bank;
    logic [ROW_W-1:0]             row_cnt;
    logic [1:0]                   occ;
    logic                         accept;
    logic                         complete;
    logic                         pop;

    assign in_ready  = (occ != 2'd2);
    assign out_valid = (occ != 2'd0);
    assign out_b     = bank[rd_bank];
    assign accept    = in_valid && in_ready;
    assign complete  = accept && ((row_cnt == ROW_W'(STEP - 1)) || in_last);
    assign pop       = out_valid && out_ready;

    // Row 0 also wipes the rest of its bank so a short tile reads back zero-padded.
    always_ff @(posedge clk) begin
        if (reset) begin
            bank <= '0;
        end else if (accept) begin
            for (int r = 0; r < STEP; r++) begin
                if (ROW_W'(r) == row_cnt)
                    bank[wr_bank][r] <= in_row;
                else if (row_cnt == '0)
                    bank[wr_bank][r] <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            row_cnt  <= '0;
            occ      <= 2'd0;
            tile_cnt <= 16'd0;
        end else begin
            if (complete) begin
                row_cnt <= '0;
                wr_bank <= ~wr_bank;
            end else if (accept) begin
                row_cnt <= row_cnt + 1'b1;
            end
            if (pop) begin
                rd_bank  <= ~rd_bank;
                tile_cnt <= tile_cnt + 16'd1;
            end
            // Simultaneous complete and pop leaves occupancy unchanged.
            case ({complete, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end
endmodule

// File: tb/tb_tc_b_tile_loader.sv
// Directed bench for tc_b_tile_loader: one task per scenario with inline checks.
module tb_tc_b_tile_loader;
    localparam int NUM_TILE = 16;
    localparam int STEP     = 4;
    localparam int DW       = 16;
    localparam int RW       = STEP * DW;
    localparam int TW       = NUM_TILE * DW;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [RW-1:0] in_row;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [TW-1:0] out_b;
    logic [15:0]   tile_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    tc_b_tile_loader #(.NUM_TILE(NUM_TILE), .STEP(STEP), .DW_DATA(DW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_row(in_row), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_b(out_b), .tile_cnt(tile_cnt)
    );

    always #5 clk = ~clk;

    // Row whose columns hold base, base+1, ... (column 0 in the low bits).
    function automatic logic [RW-1:0] mk_row(input int base);
        logic [RW-1:0] r;
        for (int c = 0; c < STEP; c++) r[c*DW +: DW] = DW'(base + c);
        return r;
    endfunction

    // Tile with the first nrows rows counting up from base, remaining rows zero.
    function automatic logic [TW-1:0] mk_tile(input int base, input int nrows);
        logic [TW-1:0] t;
        for (int e = 0; e < NUM_TILE; e++)
            t[e*DW +: DW] = (e < nrows * STEP) ? DW'(base + e) : '0;
        return t;
    endfunction

    task automatic drive(input logic v, input logic [RW-1:0] row, input logic last);
        in_valid = v;
        in_row   = row;
        in_last  = last;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_row = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        out_ready = 1'b0;
        do_reset();
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out_b !== '0) $display("FAIL reset_out_b got %h want 0", out_b); else n_pass++;
        n_checks++; if (tile_cnt !== 16'd0) $display("FAIL reset_tile_cnt got %0d want 0", tile_cnt); else n_pass++;
    endtask

    task automatic test_full_tile();
        out_ready = 1'b1;
        for (int b = 0; b < STEP; b++) begin
            drive(1'b1, mk_row(1 + b*STEP), 1'b0);
            if (b < STEP-1) begin
                n_checks++; if (out_valid !== 1'b0) $display("FAIL full_early_valid beat %0d got %b want 0", b, out_valid); else n_pass++;
            end
        end
        n_checks++; if (out_valid !== 1'b1) $display("FAIL full_valid got %b want 1", out_valid); else n_pass++;
        n_checks++; if (out_b !== mk_tile(1, 4)) $display("FAIL full_data got %h want %h", out_b, mk_tile(1, 4)); else n_pass++;
        drive(1'b0, '0, 1'b0);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL full_after_pop_valid got %b want 0", out_valid); else n_pass++;
        n_checks++; if (tile_cnt !== 16'd1) $display("FAIL full_tile_cnt got %0d want 1", tile_cnt); else n_pass++;
    endtask

    task automatic test_short_tile();
        logic [TW-1:0] ones;
        ones = '1;
        out_ready = 1'b1;
        for (int b = 0; b < STEP; b++) drive(1'b1, {RW{1'b1}}, 1'b0);
        n_checks++; if (out_b !== ones) $display("FAIL short_prior_tile got %h want all ones", out_b); else n_pass++;
        drive(1'b1, mk_row(1), 1'b0);
        drive(1'b1, mk_row(5), 1'b1);
        n_checks++; if (out_valid !== 1'b1) $display("FAIL short_valid got %b want 1", out_valid); else n_pass++;
        n_checks++; if (out_b !== mk_tile(1, 2)) $display("FAIL short_data got %h want %h", out_b, mk_tile(1, 2)); else n_pass++;
        drive(1'b0, '0, 1'b0);
        n_checks++; if (tile_cnt !== 16'd3) $display("FAIL short_tile_cnt got %0d want 3", tile_cnt); else n_pass++;
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        for (int t = 0; t < 2; t++)
            for (int b = 0; b < STEP; b++) drive(1'b1, mk_row(100*(t+1) + b*STEP), 1'b0);
        n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_ready_low got %b want 0", in_ready); else n_pass++;
        n_checks++; if (out_b !== mk_tile(100, 4)) $display("FAIL bp_tile1 got %h want %h", out_b, mk_tile(100, 4)); else n_pass++;
        drive(1'b1, mk_row(300), 1'b0);
        drive(1'b1, mk_row(300), 1'b0);
        n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_ready_held got %b want 0", in_ready); else n_pass++;
        n_checks++; if (out_b !== mk_tile(100, 4)) $display("FAIL bp_tile1_stable got %h want %h", out_b, mk_tile(100, 4)); else n_pass++;
        out_ready = 1'b1;
        drive(1'b1, mk_row(300), 1'b0);
        out_ready = 1'b0;
        n_checks++; if (out_b !== mk_tile(200, 4)) $display("FAIL bp_tile2 got %h want %h", out_b, mk_tile(200, 4)); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_ready_back got %b want 1", in_ready); else n_pass++;
        n_checks++; if (tile_cnt !== 16'd1) $display("FAIL bp_tile_cnt got %0d want 1", tile_cnt); else n_pass++;
        for (int b = 0; b < STEP; b++) drive(1'b1, mk_row(300 + b*STEP), 1'b0);
        n_checks++; if (out_b !== mk_tile(200, 4)) $display("FAIL bp_tile2_stable got %h want %h", out_b, mk_tile(200, 4)); else n_pass++;
        out_ready = 1'b1;
        drive(1'b0, '0, 1'b0);
        n_checks++; if (out_b !== mk_tile(300, 4)) $display("FAIL bp_tile3 got %h want %h", out_b, mk_tile(300, 4)); else n_pass++;
        drive(1'b0, '0, 1'b0);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_drained got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int low_ready;
        low_ready = 0;
        do_reset();
        out_ready = 1'b1;
        for (int t = 0; t < 2; t++)
            for (int b = 0; b < STEP; b++) begin
                drive(1'b1, mk_row(40 + 20*t + b*STEP), 1'b0);
                if (in_ready !== 1'b1) low_ready++;
                if (b == STEP-1) begin
                    n_checks++; if (out_b !== mk_tile(40 + 20*t, 4)) $display("FAIL b2b_tile%0d got %h want %h", t, out_b, mk_tile(40 + 20*t, 4)); else n_pass++;
                end
            end
        drive(1'b0, '0, 1'b0);
        n_checks++; if (low_ready !== 0) $display("FAIL b2b_ready_drops got %0d want 0", low_ready); else n_pass++;
        n_checks++; if (tile_cnt !== 16'd2) $display("FAIL b2b_tile_cnt got %0d want 2", tile_cnt); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL b2b_idle_valid got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0;
        for (int b = 0; b < STEP; b++) drive(1'b1, mk_row(500 + b*STEP), 1'b0);
        drive(1'b1, mk_row(600), 1'b0);
        drive(1'b1, mk_row(604), 1'b0);
        do_reset();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rmid_valid got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out_b !== '0) $display("FAIL rmid_out_b got %h want 0", out_b); else n_pass++;
        n_checks++; if (tile_cnt !== 16'd0) $display("FAIL rmid_tile_cnt got %0d want 0", tile_cnt); else n_pass++;
        for (int b = 0; b < STEP; b++) drive(1'b1, mk_row(21 + b*STEP), 1'b0);
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL rmid_new_valid got %b want 1", out_valid); else n_pass++;
        n_checks++; if (out_b !== mk_tile(21, 4)) $display("FAIL rmid_new_tile got %h want %h", out_b, mk_tile(21, 4)); else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_last   = 1'b1;
        in_row    = mk_row(7);
        // Each single-row tile completes in one edge and pops on the next.
        repeat (65536) @(posedge clk);
        #1;
        n_checks++; if (tile_cnt !== 16'hFFFF) $display("FAIL wrap_pre got %0d want 65535", tile_cnt); else n_pass++;
        drive(1'b0, '0, 1'b0);
        n_checks++; if (tile_cnt !== 16'd0) $display("FAIL wrap_zero got %0d want 0", tile_cnt); else n_pass++;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_row = '0; out_ready = 1'b0;
        test_reset();
        test_full_tile();
        test_short_tile();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
